branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 3, is the maximum number of in-flight instruction fetch requests.
REQ-002 Parameter CNT_WD, default 2, is the width of the outstanding and discard counters; it SHALL be at least clog2(MAX_OUTSTANDING+1).
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port br_valid, input, 1: ID stage holds a valid branch or jump (jirl/b/bl/beq/bne/blt/bge/bltu/bgeu).
REQ-006 Port src_1_ready, input, 1: branch operand 1 is available.
REQ-007 Port src_2_ready, input, 1: branch operand 2 is available.
REQ-008 Port br_taken_cancel, input, 1: branch unit reports that the prediction was wrong.
REQ-009 Port next_PC, input, 32: resolved target from the branch unit.
REQ-010 Port ifetch_req_fire, input, 1: fetch request accepted by instruction memory (req & addr_ok).
REQ-011 Port ifetch_resp, input, 1: fetch data returned (data_ok); responses return in order.
REQ-012 Port redirect_ready, input, 1: PC generator accepts the redirect.
REQ-013 Port id_stall, output, 1: hold the ID stage.
REQ-014 Port flush_if, output, 1: invalidate the IF/ID buffer.
REQ-015 Port redirect_valid, output, 1: redirect request to the PC generator.
REQ-016 Port redirect_pc, output, 32: redirect target.
REQ-017 Port discard_resp, output, 1: drop the current fetch response.
REQ-018 Port fetch_block, output, 1: PC generator SHALL NOT issue a fetch request this cycle.

Function
REQ-019 The FSM SHALL have four states: IDLE, WAIT_OPND, REDIRECT and DRAIN; the state encoding is free.
REQ-020 out_cnt SHALL update as follows: +1 on req_fire only, -1 on resp only, unchanged on both or neither.
REQ-021 out_cnt SHALL never exceed MAX_OUTSTANDING or drop below 0.
REQ-022 fetch_block SHALL be 1 when out_cnt==MAX_OUTSTANDING or state==REDIRECT; it is combinational.
REQ-023 "Resolve" is defined as: br_valid & src_1_ready & src_2_ready, in IDLE or WAIT_OPND.
REQ-024 In IDLE or WAIT_OPND, br_valid & ~(src_1_ready & src_2_ready) SHALL drive id_stall=1 combinationally and move to or stay in WAIT_OPND.
REQ-025 WAIT_OPND with br_valid=0 SHALL return to IDLE, with id_stall=0.
REQ-026 Resolve with br_taken_cancel=0 SHALL go to IDLE with no other outputs asserted.
REQ-027 Resolve with br_taken_cancel=1 is a mispredict; in that cycle: flush_if=1 for one cycle, and discard_resp=ifetch_resp.
REQ-028 On a mispredict, redirect_pc SHALL latch next_PC.
REQ-029 On a mispredict, disc_cnt SHALL latch out_cnt + req_fire - resp.
REQ-030 On a mispredict, the next state SHALL be REDIRECT.
REQ-031 In REDIRECT, redirect_valid=1 and redirect_pc SHALL be held stable until redirect_valid & redirect_ready.
REQ-032 On the REDIRECT handshake, the next state SHALL be DRAIN if the next disc_cnt != 0, else IDLE.
REQ-033 In REDIRECT and DRAIN, ifetch_resp with disc_cnt != 0 SHALL drive discard_resp=1 and decrement disc_cnt.
REQ-034 DRAIN SHALL go to IDLE in the cycle disc_cnt goes from 1 to 0; the first response after that is not discarded.
REQ-035 Fetch requests are allowed in DRAIN; their responses SHALL count in out_cnt only, never in disc_cnt.
REQ-036 br_valid and br_taken_cancel SHALL be ignored in REDIRECT and DRAIN, and id_stall=0 there.
REQ-037 redirect_valid SHALL be 0 in every state except REDIRECT.
REQ-038 Only one redirect SHALL be outstanding at any time.

Reset
REQ-039 When reset=1, the next edge SHALL set: state=IDLE, out_cnt=0, disc_cnt=0, redirect_pc=0.
REQ-040 Reset SHALL override any in-progress REDIRECT or DRAIN, including one mid-handshake.
REQ-041 While reset=1, id_stall, flush_if, redirect_valid, discard_resp and fetch_block SHALL all be 0.

Verification
REQ-042 Operand wait: br_valid=1 with src_2_ready=0 for 3 cycles, then 1, cancel=0 -> id_stall=1 for exactly 3 cycles, then IDLE, with no flush.
REQ-043 Mispredict with drain: out_cnt=2, cancel=1, next_PC=0x1C000040, redirect_ready=0 for 2 cycles -> flush_if pulses once; redirect_valid=1 for 3 cycles with pc 0x1C000040; exactly the first 2 responses are discarded and the 3rd is kept.
REQ-044 Simultaneous events: mispredict cycle with out_cnt=1, req_fire=1, resp=1 -> discard_resp=1 that cycle, and disc_cnt=1 afterwards.
REQ-045 No drain: out_cnt=0, mispredict, redirect_ready=1 -> redirect_valid lasts exactly 1 cycle, then IDLE, with discard_resp never 1.
REQ-046 Saturation: 3 req_fire with no resp -> fetch_block=1 and out_cnt stays 3; one resp -> fetch_block=0.
REQ-047 Reset mid-DRAIN with disc_cnt=2 -> after the edge all outputs are 0, and the next resp is not discarded.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Coordinates branch resolution in ID with the instruction fetch front end.
// Holds ID while branch operands are pending. On a mispredict it flushes the
// IF/ID buffer and issues a single redirect to the PC generator. It also
// discards the responses of every fetch that was in flight when the branch
// resolved. A saturating count of outstanding fetches throttles the PC
// generator.
//
// Parameters
//   MAX_OUTSTANDING  maximum number of in-flight fetch requests
//   CNT_WD           width of the outstanding / discard counters
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            synchronous active-high reset
//   br_valid         ID holds a valid branch/jump
//   src_1_ready      branch operand 1 available
//   src_2_ready      branch operand 2 available
//   br_taken_cancel  branch unit reports a misprediction
//   next_PC          resolved branch target
//   ifetch_req_fire  fetch request accepted by instruction memory
//   ifetch_resp      fetch data returned (in order)
//   redirect_ready   PC generator accepts the redirect
//   id_stall         hold the ID stage
//   flush_if         invalidate the IF/ID buffer
//   redirect_valid   redirect request to the PC generator
//   redirect_pc      redirect target
//   discard_resp     drop the current fetch response
//   fetch_block      PC generator must not issue a fetch this cycle
// ---------------------------------------------------------------------------
module branch_redirect_ctrl #(
  parameter int MAX_OUTSTANDING = 3,
  parameter int CNT_WD          = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic        src_1_ready,
  input  logic        src_2_ready,
  input  logic        br_taken_cancel,
  input  logic [31:0] next_PC,
  input  logic        ifetch_req_fire,
  input  logic        ifetch_resp,
  input  logic        redirect_ready,
  output logic        id_stall,
  output logic        flush_if,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        discard_resp,
  output logic        fetch_block
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    REDIRECT  = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  localparam logic [CNT_WD-1:0] MAX_CNT = CNT_WD'(MAX_OUTSTANDING);

  state_t            state, state_nxt;
  logic [CNT_WD-1:0] out_cnt, out_cnt_nxt;
  logic [CNT_WD-1:0] disc_cnt, disc_cnt_nxt;
  logic [31:0]       redirect_pc_nxt;
  logic              opnd_ready;
  logic              resolve;

  // Outstanding-fetch counter step: a simultaneous request and response
  // cancel out, and the count is clamped to [0, MAX_CNT].
  function automatic logic [CNT_WD-1:0] sat_step(input logic [CNT_WD-1:0] cnt,
                                                 input logic              inc,
                                                 input logic              dec);
    logic [CNT_WD-1:0] r;
    r = cnt;
    if (inc && !dec && (cnt < MAX_CNT)) begin
      r = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      r = cnt - 1'b1;
    end
    return r;
  endfunction

  // Discard counter step: only ever counts down, floored at zero.
  function automatic logic [CNT_WD-1:0] disc_step(input logic [CNT_WD-1:0] cnt,
                                                  input logic              dec);
    logic [CNT_WD-1:0] r;
    r = cnt;
    if (dec && (cnt != '0)) begin
      r = cnt - 1'b1;
    end
    return r;
  endfunction

  assign opnd_ready = src_1_ready & src_2_ready;
  assign resolve    = br_valid & opnd_ready;

  always_comb begin
    state_nxt       = state;
    out_cnt_nxt     = sat_step(out_cnt, ifetch_req_fire, ifetch_resp);
    disc_cnt_nxt    = disc_cnt;
    redirect_pc_nxt = redirect_pc;
    id_stall        = 1'b0;
    flush_if        = 1'b0;
    redirect_valid  = 1'b0;
    discard_resp    = 1'b0;
    fetch_block     = (out_cnt == MAX_CNT);

    case (state)
      IDLE, WAIT_OPND: begin
        if (br_valid && !opnd_ready) begin
          id_stall  = 1'b1;
          state_nxt = WAIT_OPND;
        end else if (resolve && br_taken_cancel) begin
          // Every fetch still in flight after this edge belongs to the wrong
          // path, including one accepted this cycle; a response arriving
          // this cycle is already wrong-path and is dropped directly.
          flush_if        = 1'b1;
          discard_resp    = ifetch_resp;
          redirect_pc_nxt = next_PC;
          disc_cnt_nxt    = out_cnt_nxt;
          state_nxt       = REDIRECT;
        end else begin
          state_nxt = IDLE;
        end
      end

      REDIRECT: begin
        redirect_valid = 1'b1;
        fetch_block    = 1'b1;
        if (ifetch_resp && (disc_cnt != '0)) begin
          discard_resp = 1'b1;
        end
        disc_cnt_nxt = disc_step(disc_cnt, ifetch_resp);
        if (redirect_ready) begin
          state_nxt = (disc_cnt_nxt != '0) ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        // New-path requests may issue here; they only grow out_cnt, so the
        // drain ends exactly after the last wrong-path response.
        if (ifetch_resp && (disc_cnt != '0)) begin
          discard_resp = 1'b1;
        end
        disc_cnt_nxt = disc_step(disc_cnt, ifetch_resp);
        if (disc_cnt_nxt == '0) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are quiet for the whole reset cycle, whatever the old state.
    if (reset) begin
      id_stall       = 1'b0;
      flush_if       = 1'b0;
      redirect_valid = 1'b0;
      discard_resp   = 1'b0;
      fetch_block    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_cnt     <= '0;
      disc_cnt    <= '0;
      redirect_pc <= '0;
    end else begin
      state       <= state_nxt;
      out_cnt     <= out_cnt_nxt;
      disc_cnt    <= disc_cnt_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Cycle-by-cycle directed vectors for branch_redirect_ctrl. Each record holds
// the inputs for one cycle and the outputs expected during that cycle.
// Inputs are driven just after the rising edge and outputs are sampled on the
// falling edge. A hand-written sequence covers reset during a redirect
// handshake.
//
// Input bits  : {reset, br_valid, src_1_ready, src_2_ready,
//                br_taken_cancel, ifetch_req_fire, ifetch_resp, redirect_ready}
// Expect bits : {id_stall, flush_if, redirect_valid, discard_resp, fetch_block}
// ---------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic        src_1_ready;
  logic        src_2_ready;
  logic        br_taken_cancel;
  logic [31:0] next_PC;
  logic        ifetch_req_fire;
  logic        ifetch_resp;
  logic        redirect_ready;
  logic        id_stall;
  logic        flush_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        discard_resp;
  logic        fetch_block;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] P1 = 32'h1C00_0040;
  localparam logic [31:0] P2 = 32'h1C00_0100;
  localparam logic [31:0] P3 = 32'h1C00_0200;
  localparam logic [31:0] P4 = 32'h1C00_0300;

  typedef struct {
    string       tag;
    logic [7:0]  in;
    logic [31:0] npc;
    logic [4:0]  exp;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[$];

  branch_redirect_ctrl #(
    .MAX_OUTSTANDING(3),
    .CNT_WD         (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .br_valid       (br_valid),
    .src_1_ready    (src_1_ready),
    .src_2_ready    (src_2_ready),
    .br_taken_cancel(br_taken_cancel),
    .next_PC        (next_PC),
    .ifetch_req_fire(ifetch_req_fire),
    .ifetch_resp    (ifetch_resp),
    .redirect_ready (redirect_ready),
    .id_stall       (id_stall),
    .flush_if       (flush_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .discard_resp   (discard_resp),
    .fetch_block    (fetch_block)
  );

  always #5 clk = ~clk;

  function automatic void add(input string tag, input logic [7:0] in,
                              input logic [31:0] npc, input logic [4:0] exp,
                              input logic [31:0] rpc);
    vec_t v;
    v.tag = tag;
    v.in  = in;
    v.npc = npc;
    v.exp = exp;
    v.rpc = rpc;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [7:0] in, input logic [31:0] npc);
    reset           = in[7];
    br_valid        = in[6];
    src_1_ready     = in[5];
    src_2_ready     = in[4];
    br_taken_cancel = in[3];
    ifetch_req_fire = in[2];
    ifetch_resp     = in[1];
    redirect_ready  = in[0];
    next_PC         = npc;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] exp,
                            input logic [31:0] rpc);
    check({tag, ".id_stall"},       32'(id_stall),       32'(exp[4]));
    check({tag, ".flush_if"},       32'(flush_if),       32'(exp[3]));
    check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(exp[2]));
    check({tag, ".discard_resp"},   32'(discard_resp),   32'(exp[1]));
    check({tag, ".fetch_block"},    32'(fetch_block),    32'(exp[0]));
    check({tag, ".redirect_pc"},    redirect_pc,         rpc);
  endtask

  // One cycle: inputs already applied just after the edge; sample on the
  // falling edge, then move to just past the next rising edge.
  task automatic run_cycle(input string tag, input logic [4:0] exp,
                           input logic [31:0] rpc);
    @(negedge clk);
    check_outs(tag, exp, rpc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state (outputs gated even with busy inputs)
    add("rst",      8'b1101_0110, 32'h0, 5'b00000, 32'h0);
    // operand wait: 3 stalled cycles, then resolve without cancel
    add("opw1",     8'b0110_0000, 32'h0, 5'b10000, 32'h0);
    add("opw2",     8'b0110_0000, 32'h0, 5'b10000, 32'h0);
    add("opw3",     8'b0110_0000, 32'h0, 5'b10000, 32'h0);
    add("opw4",     8'b0111_0000, 32'h0, 5'b00000, 32'h0);
    add("opw5",     8'b0000_0000, 32'h0, 5'b00000, 32'h0);
    // WAIT_OPND abandoned by br_valid dropping
    add("wdrop1",   8'b0110_0000, 32'h0, 5'b10000, 32'h0);
    add("wdrop2",   8'b0000_0000, 32'h0, 5'b00000, 32'h0);
    // mispredict with drain: two fetches outstanding, ready low twice
    add("mp_f1",    8'b0000_0100, 32'h0, 5'b00000, 32'h0);
    add("mp_f2",    8'b0000_0100, 32'h0, 5'b00000, 32'h0);
    add("mp_res",   8'b0111_1000, P1,    5'b01000, 32'h0);
    add("mp_rd1",   8'b0111_1000, 32'h0, 5'b00101, P1);
    add("mp_rd2",   8'b0000_0010, 32'h0, 5'b00111, P1);
    add("mp_rd3",   8'b0000_0001, 32'h0, 5'b00101, P1);
    add("mp_dr1",   8'b0110_0100, 32'h0, 5'b00000, P1);
    add("mp_dr2",   8'b0000_0010, 32'h0, 5'b00010, P1);
    add("mp_keep",  8'b0000_0010, 32'h0, 5'b00000, P1);
    // mispredict with simultaneous request and response
    add("sim_f",    8'b0000_0100, 32'h0, 5'b00000, P1);
    add("sim_mp",   8'b0111_1110, P2,    5'b01010, P1);
    add("sim_rd",   8'b0000_0001, 32'h0, 5'b00101, P2);
    add("sim_dr",   8'b0000_0010, 32'h0, 5'b00010, P2);
    add("sim_f2",   8'b0000_0100, 32'h0, 5'b00000, P2);
    add("sim_keep", 8'b0000_0010, 32'h0, 5'b00000, P2);
    // mispredict with nothing in flight, immediate handshake
    add("nd_mp",    8'b0111_1000, P3,    5'b01000, P2);
    add("nd_rd",    8'b0000_0011, 32'h0, 5'b00101, P3);
    add("nd_idle",  8'b0000_0000, 32'h0, 5'b00000, P3);
    add("nd_br",    8'b0110_0000, 32'h0, 5'b10000, P3);
    add("nd_q",     8'b0000_0000, 32'h0, 5'b00000, P3);
    // saturation at 3 and floor at 0
    add("sat_f1",   8'b0000_0100, 32'h0, 5'b00000, P3);
    add("sat_f2",   8'b0000_0100, 32'h0, 5'b00000, P3);
    add("sat_f3",   8'b0000_0100, 32'h0, 5'b00000, P3);
    add("sat_f4",   8'b0000_0100, 32'h0, 5'b00001, P3);
    add("sat_hold", 8'b0000_0000, 32'h0, 5'b00001, P3);
    add("sat_r1",   8'b0000_0010, 32'h0, 5'b00001, P3);
    add("sat_r1q",  8'b0000_0000, 32'h0, 5'b00000, P3);
    add("sat_r2",   8'b0000_0010, 32'h0, 5'b00000, P3);
    add("sat_r3",   8'b0000_0010, 32'h0, 5'b00000, P3);
    add("sat_und",  8'b0000_0010, 32'h0, 5'b00000, P3);
    add("sat_u1",   8'b0000_0100, 32'h0, 5'b00000, P3);
    add("sat_u2",   8'b0000_0100, 32'h0, 5'b00000, P3);
    add("sat_u3",   8'b0000_0100, 32'h0, 5'b00000, P3);
    add("sat_full", 8'b0000_0000, 32'h0, 5'b00001, P3);
    add("dn1",      8'b0000_0010, 32'h0, 5'b00001, P3);
    add("dn2",      8'b0000_0010, 32'h0, 5'b00000, P3);
    add("dn3",      8'b0000_0010, 32'h0, 5'b00000, P3);
    // reset in DRAIN with two responses still to discard
    add("g_f1",     8'b0000_0100, 32'h0, 5'b00000, P3);
    add("g_f2",     8'b0000_0100, 32'h0, 5'b00000, P3);
    add("g_mp",     8'b0111_1000, P4,    5'b01000, P3);
    add("g_rd",     8'b0000_0001, 32'h0, 5'b00101, P4);
    add("g_dr",     8'b0000_0000, 32'h0, 5'b00000, P4);
    add("g_rst",    8'b1111_1111, P1,    5'b00000, P4);
    add("g_resp",   8'b0000_0010, 32'h0, 5'b00000, 32'h0);
    add("g_f",      8'b0000_0100, 32'h0, 5'b00000, 32'h0);
    add("g_r",      8'b0000_0010, 32'h0, 5'b00000, 32'h0);
    // reset with the outstanding counter full
    add("i_f1",     8'b0000_0100, 32'h0, 5'b00000, 32'h0);
    add("i_f2",     8'b0000_0100, 32'h0, 5'b00000, 32'h0);
    add("i_f3",     8'b0000_0100, 32'h0, 5'b00000, 32'h0);
    add("i_rst",    8'b1110_0000, 32'h0, 5'b00000, 32'h0);
    add("i_after",  8'b0000_0000, 32'h0, 5'b00000, 32'h0);

    drive(8'b1000_0000, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in, vecs[i].npc);
      run_cycle(vecs[i].tag, vecs[i].exp, vecs[i].rpc);
    end

    // reset arriving in the same cycle as the redirect handshake
    drive(8'b0111_1000, P2);
    run_cycle("h_mp", 5'b01000, 32'h0);
    drive(8'b1000_0001, 32'h0);
    run_cycle("h_rst", 5'b00000, P2);
    drive(8'b0000_0001, 32'h0);
    run_cycle("h_q", 5'b00000, 32'h0);
    drive(8'b0110_0000, 32'h0);
    run_cycle("h_br", 5'b10000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
